// File: rtl/dotp_pkg.sv
// Shared types and elaboration-time helpers for the dot-product MAC datapath
// (state encoding, clog2, accumulator width).
package dotp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Wide enough to hold VEC_LEN worst-case signed products without overflow.
  function automatic int acc_width(input int data_width, input int vec_len);
    return 2 * data_width + clog2(vec_len);
  endfunction

endpackage

// File: rtl/dotp_mac_datapath_if.sv
// Element-pair stream in, dot-product result out, plus FSM state for observation.
// Handshake: a beat is transferred on any rising edge where in_valid=1 while the
// block is accumulating; result is qualified by a one-cycle result_valid pulse.
interface dotp_mac_datapath_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int VEC_LEN    = 5
);
  import dotp_pkg::*;

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, VEC_LEN);

  logic                         start;
  logic                         in_valid;
  logic [ADDR_WIDTH-1:0]        in_addr;
  logic signed [DATA_WIDTH-1:0] in_a;
  logic signed [DATA_WIDTH-1:0] in_b;
  logic signed [ACC_WIDTH-1:0]  result;
  logic                         result_valid;
  logic                         busy;
  logic                         addr_err;
  state_e                       state;

  modport master (
    output start, in_valid, in_addr, in_a, in_b,
    input  result, result_valid, busy, addr_err, state
  );

  modport slave (
    input  start, in_valid, in_addr, in_a, in_b,
    output result, result_valid, busy, addr_err, state
  );

endinterface

// File: rtl/dotp_mult_stage.sv
// Registered signed multiplier: one product per accepted beat, with a valid flag
// that the accumulator consumes on the following cycle.
module dotp_mult_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           clr_i,
  input  logic                           en_i,
  input  logic signed [DATA_WIDTH-1:0]   a_i,
  input  logic signed [DATA_WIDTH-1:0]   b_i,
  output logic signed [2*DATA_WIDTH-1:0] prod_o,
  output logic                           prod_vld_o
);

  logic signed [2*DATA_WIDTH-1:0] prod_q;
  logic                           prod_vld_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      prod_vld_q <= en_i;
      if (en_i) begin
        prod_q <= a_i * b_i;
      end
    end
  end

  assign prod_o     = prod_q;
  assign prod_vld_o = prod_vld_q;

endmodule

// File: rtl/dotp_mac_datapath.sv
// Dot-product MAC: counts beats, accumulates pipelined products, hands off the result.
// Optional build macro DOTP_ADDR_CHECK_EN adds a sticky in_addr/elem_cnt mismatch flag.
module dotp_mac_datapath
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int VEC_LEN    = 5
) (
  input  logic              clk,
  input  logic              rst,
  dotp_mac_datapath_if.slave bus
);

  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, VEC_LEN);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VEC_LEN - 1);

  state_e                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        elem_cnt_q, elem_cnt_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]  result_q, result_d;
  logic                         result_valid_q, result_valid_d;
  logic                         busy_q, busy_d;
  logic                         addr_err_q, addr_err_d;
  logic                         start_acc;
  logic                         beat;
  logic signed [PROD_WIDTH-1:0] prod;
  logic                         prod_vld;

  dotp_mult_stage #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
    .clk        (clk),
    .clr_i      (rst | start_acc),
    .en_i       (beat),
    .a_i        (bus.in_a),
    .b_i        (bus.in_b),
    .prod_o     (prod),
    .prod_vld_o (prod_vld)
  );

`ifndef DOTP_ADDR_CHECK_EN
  logic unused_addr;
  assign unused_addr = ^bus.in_addr;
`endif

  always_comb begin
    state_d        = state_q;
    elem_cnt_d     = elem_cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    busy_d         = busy_q;
    addr_err_d     = addr_err_q;
    start_acc      = 1'b0;
    beat           = 1'b0;
    // The previous beat's product lands in acc while the current beat multiplies.
    acc_d          = prod_vld ? acc_q + ACC_WIDTH'(prod) : acc_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          start_acc  = 1'b1;
          state_d    = ACCUM;
          elem_cnt_d = '0;
          acc_d      = '0;
          busy_d     = 1'b1;
          addr_err_d = 1'b0;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          beat       = 1'b1;
          elem_cnt_d = elem_cnt_q + 1'b1;
`ifdef DOTP_ADDR_CHECK_EN
          if (bus.in_addr != elem_cnt_q) begin
            addr_err_d = 1'b1;
          end
`endif
          if (elem_cnt_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d        = DONE;
        result_d       = acc_d;
        result_valid_d = 1'b1;
        busy_d         = 1'b0;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      elem_cnt_q     <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      addr_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      elem_cnt_q     <= elem_cnt_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      addr_err_q     <= addr_err_d;
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.addr_err     = addr_err_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_dotp_mac_datapath.sv
// Directed-vector bench for dotp_mac_datapath: the driver queues the hand-computed
// dot product per run, and an independent monitor checks each result_valid pulse.
module tb_dotp_mac_datapath;
  import dotp_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int VL    = 5;
  localparam int ACC_W = 2 * DW + 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dotp_mac_datapath_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VEC_LEN(VL)) bus ();

  dotp_mac_datapath #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VEC_LEN(VL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [ACC_W-1:0] exp_q[$];

  int a_ramp [VL] = '{1, 2, 3, 4, 5};
  int v_one  [VL] = '{1, 1, 1, 1, 1};
  int v_m1   [VL] = '{-1, -1, -1, -1, -1};
  int v_m128 [VL] = '{-128, -128, -128, -128, -128};
  int v_p127 [VL] = '{127, 127, 127, 127, 127};
  int v_two  [VL] = '{2, 2, 2, 2, 2};
  int v_three[VL] = '{3, 3, 3, 3, 3};
  int idx_ok [VL] = '{0, 1, 2, 3, 4};
  int idx_bad[VL] = '{0, 1, 3, 3, 4};

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [ACC_W-1:0] exp_v;
    if (bus.result_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious result_valid", 1, 0);
      end else begin
        exp_v = exp_q.pop_front();
        check("result", $signed(bus.result), $signed(exp_v));
      end
      check("busy at result_valid", bus.busy, 0);
    end
  end

  // driver: one full vector; abort_after>0 resets after that many beats
  task automatic run(input string name, input int a[VL], input int b[VL],
                     input int addr[VL], input int want, input bit gaps,
                     input int extra, input bit mid_start, input int abort_after);
    int  lat;
    bit  err_m;
    err_m = 1'b0;
    if (abort_after == 0) exp_q.push_back(ACC_W'(want));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({name, " busy after start"}, bus.busy, 1);
    check({name, " addr_err after start"}, bus.addr_err, 0);
    for (int i = 0; i < VL; i++) begin
      if (gaps) begin
        repeat ($urandom_range(1, 3)) tick();
      end
      bus.in_valid = 1'b1;
      bus.in_a     = DW'(a[i]);
      bus.in_b     = DW'(b[i]);
      bus.in_addr  = AW'(addr[i]);
      bus.start    = mid_start && (i == 1);
      tick();
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
`ifdef DOTP_ADDR_CHECK_EN
      if (addr[i] != i) err_m = 1'b1;
`endif
      check({name, " addr_err"}, bus.addr_err, err_m);
      if (abort_after == i + 1) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check({name, " rst result"}, bus.result, 0);
        check({name, " rst result_valid"}, bus.result_valid, 0);
        check({name, " rst busy"}, bus.busy, 0);
        check({name, " rst addr_err"}, bus.addr_err, 0);
        check({name, " rst state"}, bus.state, IDLE);
        repeat (4) tick();
        return;
      end
    end
    // junk beats after the last one must be ignored
    bus.in_valid = (extra > 0);
    bus.in_a     = 8'sd127;
    bus.in_b     = 8'sd127;
    lat = 0;
    while (!bus.result_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, " edges from last beat to result_valid"}, lat, 1);
    if (extra > 1) tick();
    bus.in_valid = 1'b0;
    tick();
    check({name, " result held"}, bus.result, want);
    check({name, " addr_err held"}, bus.addr_err, err_m);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    repeat (2) tick();
    check("reset result", bus.result, 0);
    check("reset result_valid", bus.result_valid, 0);
    check("reset busy", bus.busy, 0);
    check("reset addr_err", bus.addr_err, 0);
    check("reset state", bus.state, IDLE);
    rst = 1'b0;
    tick();

    run("basic",      a_ramp, v_one,   idx_ok,  15,     0, 0, 0, 0);
    run("neg_neg",    v_m128, v_m128,  idx_ok,  81920,  0, 0, 0, 0);
    run("neg_pos",    v_m128, v_p127,  idx_ok,  -81280, 0, 0, 0, 0);
    run("stalls",     a_ramp, v_one,   idx_ok,  15,     1, 0, 0, 0);
    run("mid_start",  a_ramp, v_one,   idx_ok,  15,     0, 0, 1, 0);
    run("extra_beats", a_ramp, v_one,  idx_ok,  15,     0, 2, 0, 0);
    run("abort",      a_ramp, v_one,   idx_ok,  0,      0, 0, 0, 3);
    run("after_rst",  v_two,  v_three, idx_ok,  30,     0, 0, 0, 0);
    run("addr_seq",   a_ramp, v_m1,    idx_bad, -15,    0, 0, 0, 0);
    run("addr_clear", v_two,  v_three, idx_ok,  30,     0, 0, 0, 0);

    repeat (3) tick();
    check("expected queue drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dotp_mac_datapath.md
# dotp_mac_datapath

Arithmetic stage directly downstream of the dot-product control unit. It consumes the element-pair stream that the control unit sequences with its write-enable and address counter, multiplies each pair, and accumulates the products. After the last element it presents the signed dot product with a one-cycle valid pulse. The controller owns addressing; this block owns the arithmetic, element counting and result handoff.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each signed input element
- ADDR_WIDTH, 3, width of the element index driven by the control unit
- VEC_LEN, 5, elements per vector (indices 0..VEC_LEN-1); must satisfy 1 ≤ VEC_LEN ≤ 2^ADDR_WIDTH

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begins a new dot product; clears the accumulator
- in_valid  in  1  element-pair strobe (the control unit's we)
- in_addr  in  ADDR_WIDTH  element index (the control unit's addr)
- in_a  in  DATA_WIDTH  signed element of vector A
- in_b  in  DATA_WIDTH  signed element of vector B
- result  out  ACC_WIDTH  signed dot product; ACC_WIDTH = 2*DATA_WIDTH + clog2(VEC_LEN)
- result_valid  out  1  one-cycle pulse when result is final
- busy  out  1  high from an accepted start until result_valid
- addr_err  out  1  sticky index-mismatch flag (only when the address check is compiled in; otherwise tied 0)

## Operation
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE: start=1 clears acc, prod_reg, elem_cnt and addr_err, then goes to ACCUM. in_valid is ignored in IDLE.
- ACCUM: each cycle with in_valid=1 is one beat.
  - prod_reg <= in_a*in_b (signed, 2*DATA_WIDTH bits).
  - prod_vld <= 1.
  - elem_cnt increments.
  - After beat number VEC_LEN, the FSM goes to DRAIN.
  - Cycles with in_valid=0 are stalls. They do not change elem_cnt or acc.
- Every cycle with prod_vld=1, acc <= acc + sign-extended prod_reg. The stage is pipelined, so a beat and the previous product's accumulation happen in the same cycle.
- DRAIN: the last product is accumulated, then the FSM goes to DONE.
- DONE: result_valid=1 for exactly one cycle and result=acc. The FSM then returns to IDLE.
- result holds its value until the next start clears acc. A new run is not visible on result until its own DONE.
- start in ACCUM, DRAIN or DONE is ignored. No restart occurs mid-vector.
- in_valid beyond VEC_LEN beats, or in DRAIN or DONE, is ignored.
- Overflow cannot occur: ACC_WIDTH covers VEC_LEN worst-case products, for example (-128)*(-128)*5 = 81920 < 2^18.

## Timing
- Reset values: result=0, result_valid=0, busy=0, addr_err=0, state=IDLE, acc=0, elem_cnt=0, prod_vld=0.
- Reset mid-operation aborts the run. Nothing is output for the aborted vector.
- Latency: the last beat is sampled at edge T. acc is final at edge T+1. result_valid is high in the cycle after edge T+1, i.e. two cycles after the last beat.
- busy rises the cycle after the edge that accepted start. It falls in the same edge that raises result_valid.
- start and the first in_valid may coincide: start is accepted, but that beat is dropped. The upstream controller raises we one cycle after start.
- Back-to-back runs: start is accepted in the first cycle back in IDLE, which is the cycle after result_valid.

## Configuration
- DOTP_ADDR_CHECK_EN
  - Defined: on every accepted beat, in_addr is compared with elem_cnt. A mismatch sets addr_err, which stays set until the next start or rst. Accumulation proceeds regardless.
  - Undefined: in_addr is unused, the comparator is absent, and addr_err is constant 0.

## Structure
- Package dotp_pkg holds:
  - the state enum (IDLE, ACCUM, DRAIN, DONE);
  - the function computing ACC_WIDTH from DATA_WIDTH and VEC_LEN;
  - the clog2 helper.
- One sub-module, dotp_mult_stage: the registered signed multiplier producing prod_reg and prod_vld, with synchronous clear on rst or on an accepted start.
- FSM, counter, accumulator and address check live in the top module.

## Test plan
- Basic run: rst, then start, then 5 consecutive beats of A=(1,2,3,4,5), B=(1,1,1,1,1) -> result=15 with one-cycle result_valid 2 cycles after the last beat; busy low in the same cycle.
- Signed extremes: A all -128, B all -128 -> result=81920. A=(-128,...), B=(127,...) -> result=-81280.
- Stalls: the same vectors as the basic run with in_valid=0 gaps of 1–3 cycles between beats -> result=15. result_valid timing stays relative to the last beat.
- Ignored inputs:
  - start asserted during ACCUM -> no restart; result unchanged.
  - 2 extra in_valid beats after the fifth -> no effect on result.
- Reset mid-run: rst after the 3rd beat -> all outputs 0 and no result_valid. A following full run of A=(2,2,2,2,2), B=(3,3,3,3,3) -> result=30.
- With DOTP_ADDR_CHECK_EN defined: in_addr sequence 0,1,3,3,4 -> addr_err=1 from the 3rd beat on; result still correct. The next start clears addr_err to 0.
